// File: rtl/bnn_core_sequencer.sv
// Issue-side sequencer for the BNN core: config, bias/operand streaming, per-bin clear/acc/bin, result readback.
// Optional BNN_SEQ_PERF_EN adds the perf_cycles / perf_stalls counters and ports.
module bnn_core_sequencer #(
  parameter int LOAD_WORDS = 4,
  parameter int OUT_W      = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg_n_bpug,
  input  logic [3:0]       cfg_n_groups,
  input  logic [2:0]       cfg_height,
  input  logic             cfg_pool,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [22:0]      core_instr,
  output logic [31:0]      core_data,
  input  logic [31:0]      core_result,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef BNN_SEQ_PERF_EN
  output logic [31:0]      perf_cycles,
  output logic [31:0]      perf_stalls,
`endif
  output logic             busy,
  output logic             done
);

  // state  | meaning
  // IDLE   | waiting for start
  // CFG    | program BPUG enable mask and height
  // BIAS   | forward 2 bias words for the current group
  // LOAD   | forward LOAD_WORDS operand words for the current window
  // CLEAR  | accumulators <- bias
  // ACC    | accumulate, one BPUG per cycle
  // BIN    | binarise (and OR-pool) the window
  // RD_LO  | read low result word
  // RD_HI  | read high result word
  // OUT    | hold the group record until accepted
  // DONE   | one-cycle completion pulse
  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] CFG   = 4'd1;
  localparam logic [3:0] BIAS  = 4'd2;
  localparam logic [3:0] LOAD  = 4'd3;
  localparam logic [3:0] CLEAR = 4'd4;
  localparam logic [3:0] ACC   = 4'd5;
  localparam logic [3:0] BIN   = 4'd6;
  localparam logic [3:0] RD_LO = 4'd7;
  localparam logic [3:0] RD_HI = 4'd8;
  localparam logic [3:0] OUT   = 4'd9;
  localparam logic [3:0] DONE  = 4'd10;

  localparam logic [3:0] LW_LAST = 4'(LOAD_WORDS - 1);

  logic [3:0]  state;
  logic [1:0]  win_cnt;
  logic [2:0]  bin_cnt;
  logic [3:0]  word_cnt;
  logic [3:0]  bpug_cnt;
  logic [3:0]  grp_cnt;
  logic [3:0]  n_bpug_q;
  logic [3:0]  n_groups_q;
  logic [2:0]  height_q;
  logic        pool_q;
  logic [15:0] bpug_mask;

  assign bpug_mask = ~(16'hFFFE << n_bpug_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      bin_cnt    <= '0;
      word_cnt   <= '0;
      bpug_cnt   <= '0;
      grp_cnt    <= '0;
      n_bpug_q   <= '0;
      n_groups_q <= '0;
      height_q   <= '0;
      pool_q     <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_bpug_q   <= cfg_n_bpug;
            n_groups_q <= cfg_n_groups;
            height_q   <= cfg_height;
            pool_q     <= cfg_pool;
            win_cnt    <= '0;
            bin_cnt    <= '0;
            word_cnt   <= '0;
            bpug_cnt   <= '0;
            grp_cnt    <= '0;
            state      <= CFG;
          end
        end
        CFG: state <= BIAS;
        BIAS: begin
          if (in_valid) begin
            if (word_cnt == 4'd1) begin
              word_cnt <= '0;
              state    <= LOAD;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (word_cnt == LW_LAST) begin
              word_cnt <= '0;
              state    <= CLEAR;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end
        end
        CLEAR: begin
          bpug_cnt <= '0;
          state    <= ACC;
        end
        ACC: begin
          if (bpug_cnt == n_bpug_q) begin
            bpug_cnt <= '0;
            state    <= BIN;
          end else begin
            bpug_cnt <= bpug_cnt + 4'd1;
          end
        end
        BIN: begin
          if (pool_q && (win_cnt != 2'd3)) begin
            win_cnt <= win_cnt + 2'd1;
            state   <= LOAD;
          end else begin
            win_cnt <= '0;
            bin_cnt <= bin_cnt + 3'd1;
            state   <= (bin_cnt == 3'd7) ? RD_LO : LOAD;
          end
        end
        RD_LO: begin
          out_data[31:0] <= core_result;
          state          <= RD_HI;
        end
        RD_HI: begin
          out_data[63:32] <= core_result;
          state           <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            if (grp_cnt < n_groups_q) begin
              grp_cnt <= grp_cnt + 4'd1;
              state   <= BIAS;
            end else begin
              grp_cnt <= '0;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction/data bus is a pure decode of state and counters; stalled stream cycles issue NOP.
  always_comb begin
    core_instr = '0;
    core_data  = '0;
    case (state)
      CFG: begin
        core_instr[15]    = 1'b1;
        core_instr[8]     = 1'b1;
        core_data[15:0]   = bpug_mask;
        core_data[18:16]  = height_q;
      end
      BIAS: begin
        if (in_valid) begin
          core_instr[11] = 1'b1;
          core_data      = in_data;
        end
      end
      LOAD: begin
        if (in_valid) begin
          core_instr[15]    = 1'b1;
          core_instr[16]    = word_cnt[0];
          core_instr[19:17] = word_cnt[3:1];
          core_data         = in_data;
        end
      end
      CLEAR: core_instr[0] = 1'b1;
      ACC: begin
        core_instr[9]   = 1'b1;
        core_instr[4:1] = bpug_cnt;
      end
      BIN: begin
        core_instr[10] = 1'b1;
        if (pool_q) begin
          core_instr[12] = 1'b1;
          core_instr[13] = win_cnt[0];
          core_instr[6]  = win_cnt[1];
        end
      end
      RD_LO: core_instr[14] = 1'b1;
      RD_HI: begin
        core_instr[14] = 1'b1;
        core_instr[6]  = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready  = (state == BIAS) || (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

`ifdef BNN_SEQ_PERF_EN
  logic stall_cyc;
  assign stall_cyc = (in_ready && !in_valid) || (out_valid && !out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else begin
      if (busy && !(&perf_cycles))
        perf_cycles <= perf_cycles + 32'd1;
      if (stall_cyc && !(&perf_stalls))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
